// File: rtl/job_sequencer.sv
// Job sequencer: accepts a host command when idle and not held off by rt,
// runs a data phase of cmd_len+1 cycles, and terminates with exactly one of
// endd (normal), stop (abort) or err (fault, held ERR_HOLD cycles). Each
// termination raises a one-cycle completion report on the following cycle.
// An independent ACK_LAT-deep delay line turns req into ack. ACK_LAT must be
// at least 2.
module job_sequencer #(
    parameter int LEN_W    = 8,
    parameter int ERR_HOLD = 2,
    parameter int ACK_LAT  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort_i,
    input  logic             fault_i,
    input  logic             rt,
    input  logic             req,
    output logic             enable,
    output logic             start,
    output logic             rdy,
    output logic             err,
    output logic             stop,
    output logic             endd,
    output logic             interrupt,
    output logic             status,
    output logic             status_valid,
    output logic             ack
);

    // S_ERR1 is the termination cycle of a fault (err with start/rdy still up);
    // S_ERRH covers the remaining ERR_HOLD-1 cycles of the err burst.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_ERR1 = 2'd2,
        S_ERRH = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         hold_q, hold_d;
    logic               rt_d1_q, rt_d2_q;
    logic [ACK_LAT-1:0] ack_pipe_q;
    logic               status_valid_q;
    logic               status_q;

    // State, counters, rt history, completion report and ack delay line.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            hold_q         <= '0;
            rt_d1_q        <= 1'b0;
            rt_d2_q        <= 1'b0;
            ack_pipe_q     <= '0;
            status_valid_q <= 1'b0;
            status_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hold_q         <= hold_d;
            rt_d1_q        <= rt;
            rt_d2_q        <= rt_d1_q;
            ack_pipe_q     <= {ack_pipe_q[ACK_LAT-2:0], req};
            // The report describes the termination seen in the cycle before.
            status_valid_q <= interrupt;
            status_q       <= interrupt & (stop | err);
        end
    end

    // Next-state logic: command accept, run countdown, fault hold sequencing.
    // NOTE: every variable gets a default at the top so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && enable) begin
                    state_d = S_RUN;
                    cnt_d   = cmd_len;
                end
            end
            S_RUN: begin
                // Fault outranks abort, which outranks normal completion.
                if (fault_i) begin
                    state_d = S_ERR1;
                end else if (abort_i || (cnt_q == '0)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            S_ERR1: begin
                if (ERR_HOLD > 1) begin
                    state_d = S_ERRH;
                    hold_d  = 2'(ERR_HOLD - 2);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ERRH: begin
                if (hold_q == 2'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q - 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: handshake levels from state, stop/endd from live inputs.
    always_comb begin
        // Gating with rst keeps enable low while reset is held.
        enable       = rst && (state_q == S_IDLE) && !rt && !rt_d1_q && !rt_d2_q;
        start        = (state_q == S_RUN) || (state_q == S_ERR1);
        rdy          = start;
        err          = (state_q == S_ERR1) || (state_q == S_ERRH);
        stop         = (state_q == S_RUN) && !fault_i && abort_i;
        endd         = (state_q == S_RUN) && !fault_i && !abort_i && (cnt_q == '0);
        interrupt    = stop || endd || (state_q == S_ERR1);
        status       = status_q;
        status_valid = status_valid_q;
        ack          = ack_pipe_q[ACK_LAT-1];
    end

endmodule
